// File: rtl/inv_player_if.sv
// Byte-stream bundle between the inverse permutation layer and its neighbours.
// The slave modport is the inv_player side; the master modport is the
// producer/consumer side that feeds permuted bytes and drains recovered bytes.
interface inv_player_if #(
    parameter int IDXW = 6
);
    logic [7:0]      in_data;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic [IDXW-1:0] out_idx;
    logic            busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_idx, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_idx, busy
    );
endinterface

// File: rtl/inv_player.sv
// Serial inverse bit-permutation layer for the Spongent state.
// Permuted bytes are scattered into a state register as they arrive, and the
// recovered state is then streamed back out one byte per beat.
module inv_player #(
    parameter int STATE_BITS = 264,
    parameter int NBYTES     = STATE_BITS / 8,
    parameter int IDXW       = 6
) (
    input logic         clk,
    input logic         rst,
    inv_player_if.slave bus
);
    localparam int M = STATE_BITS - 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

    typedef enum logic {
        LOAD,
        DRAIN
    } fsm_t;

    fsm_t                  fsm;
    logic [IDXW-1:0]       cnt;
    logic [STATE_BITS-1:0] state_reg;
    logic [STATE_BITS-1:0] load_next;
    logic                  busy_reg;

    // Input bit i lands at (4*i) mod M, so state bit j is fed by input bit
    // (j*STATE_BITS/4) mod M (4*STATE_BITS/4 = M+1 = 1 mod M). Each state bit
    // therefore has one fixed source beat and lane, resolved at elaboration.
    for (genvar j = 0; j < STATE_BITS; j++) begin : g_bit
        localparam int SRC = (j == M) ? M : ((j * (STATE_BITS / 4)) % M);
        localparam logic [IDXW-1:0] SRC_BEAT = IDXW'(SRC / 8);
        localparam logic [2:0]      SRC_LANE = 3'(SRC % 8);
        assign load_next[j] = (cnt == SRC_BEAT) ? bus.in_data[SRC_LANE] : state_reg[j];
    end

    // Two-phase controller: collect NBYTES permuted beats, then drain NBYTES
    // recovered beats, wiping the state between blocks so no residue leaks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= LOAD;
            cnt       <= '0;
            state_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (fsm)
                LOAD: begin
                    if (bus.in_valid) begin
                        state_reg <= load_next;
                        busy_reg  <= 1'b1;
                        if (cnt == LAST) begin
                            cnt <= '0;
                            fsm <= DRAIN;
                        end else begin
                            cnt <= cnt + IDXW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            state_reg <= '0;
                            busy_reg  <= 1'b0;
                            fsm       <= LOAD;
                        end else begin
                            cnt <= cnt + IDXW'(1);
                        end
                    end
                end
                default: begin
                    fsm <= LOAD;
                    cnt <= '0;
                end
            endcase
        end
    end

    // Outputs come only from registered state; data and index read as zero
    // outside DRAIN so a partially loaded block is never exposed.
    always_comb begin
        bus.in_ready  = (fsm == LOAD);
        bus.out_valid = (fsm == DRAIN);
        bus.out_idx   = (fsm == DRAIN) ? cnt : '0;
        bus.out_data  = (fsm == DRAIN) ? state_reg[{cnt, 3'b000} +: 8] : 8'h00;
        bus.busy      = busy_reg;
    end
endmodule

// File: tb/tb_inv_player.sv
// Scoreboard bench for inv_player: stimulus pushes expected output beats,
// a monitor pops and compares them whenever a beat is handed over.
module tb_inv_player;
    localparam int STATE_BITS = 264;
    localparam int NBYTES     = 33;
    localparam int IDXW       = 6;
    localparam int M          = STATE_BITS - 1;

    typedef struct {
        logic [7:0]      data;
        logic [IDXW-1:0] idx;
    } exp_t;

    typedef logic [7:0] blk_t [NBYTES];

    typedef struct {
        int         ib;
        logic [7:0] iv;
        int         ob;
        logic [7:0] ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_out_cyc = 0;
    int   ready_gap = 0;
    int   in_gap = 0;
    int   stall_arm = 0;
    exp_t exp_q[$];

    // Directed impulses: input beat/value and hand-computed output beat/value.
    vec_t vecs [7] = '{
        '{0,  8'h02, 0,  8'h10},
        '{8,  8'h04, 0,  8'h02},
        '{32, 8'h40, 32, 8'h08},
        '{32, 8'h80, 32, 8'h80},
        '{0,  8'h01, 0,  8'h01},
        '{0,  8'h04, 1,  8'h01},
        '{2,  8'h10, 10, 8'h01}
    };

    inv_player_if #(.IDXW(IDXW)) bus ();

    inv_player #(
        .STATE_BITS(STATE_BITS),
        .NBYTES(NBYTES),
        .IDXW(IDXW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // Monitor: every accepted output beat is compared against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", 32'(bus.out_idx), 32'hFFFF);
            end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("out_data[%0d]", e.idx), 32'(bus.out_data), 32'(e.data));
                checkOutput($sformatf("out_idx[%0d]", e.idx), 32'(bus.out_idx), 32'(e.idx));
                if (int'(e.idx) == NBYTES - 1) last_out_cyc = cyc;
            end
        end
    end

    // Sink model: random out_ready gaps, plus a 5-cycle hold at beat 10 when armed.
    initial begin
        int stalled;
        stalled = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_arm == 0) stalled = 0;
            if (stall_arm != 0 && bus.out_valid && int'(bus.out_idx) == 10 && stalled < 5) begin
                bus.out_ready = 1'b0;
                stalled++;
            end else begin
                bus.out_ready = ($urandom_range(99) >= ready_gap);
            end
        end
    end

    task automatic sendBeat(input logic [7:0] b, output int acc_cyc);
        int budget;
        budget = 0;
        if (in_gap > 0) begin
            for (int g = 0; g < 3; g++) begin
                if ($urandom_range(99) < in_gap) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && budget < 500) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!bus.in_ready) checkOutput("in_ready_timeout", 32'(bus.in_ready), 32'h1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic applyStimulus(input blk_t blk, input blk_t want, output int first_cyc);
        int c;
        first_cyc = 0;
        for (int n = 0; n < NBYTES; n++) exp_q.push_back('{data: want[n], idx: IDXW'(n)});
        for (int n = 0; n < NBYTES; n++) begin
            sendBeat(blk[n], c);
            if (n == 0) first_cyc = c;
        end
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && budget < 3000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        checkOutput("drain_left", 32'(exp_q.size()), 32'h0);
        checkOutput("busy_idle", 32'(bus.busy), 32'h0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(bus.in_ready), 32'h1);
        checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        checkOutput({tag, "_out_data"}, 32'(bus.out_data), 32'h0);
        checkOutput({tag, "_out_idx"}, 32'(bus.out_idx), 32'h0);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        blk_t blk;
        blk_t want;
        int   t0;
        int   c;
        int   p;
        int   budget;
        logic [STATE_BITS-1:0] orig;
        logic [STATE_BITS-1:0] perm;

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #12;
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed impulse blocks, no gaps; the first one also times the block.
        ready_gap = 0;
        in_gap = 0;
        for (int v = 0; v < 7; v++) begin
            for (int n = 0; n < NBYTES; n++) begin
                blk[n]  = 8'h00;
                want[n] = 8'h00;
            end
            blk[vecs[v].ib]  = vecs[v].iv;
            want[vecs[v].ob] = vecs[v].ov;
            applyStimulus(blk, want, t0);
            checkOutput("busy_drain", 32'(bus.busy), 32'h1);
            checkOutput("in_ready_drain", 32'(bus.in_ready), 32'h0);
            waitDrain();
            if (v == 0) checkOutput("block_cycles", 32'(last_out_cyc - t0), 32'd65);
        end

        // All-ones block is a fixed pattern; idx stepping is checked by the monitor.
        for (int n = 0; n < NBYTES; n++) begin
            blk[n]  = 8'hFF;
            want[n] = 8'hFF;
        end
        applyStimulus(blk, want, t0);
        waitDrain();

        // Backpressure: input beat 2 = 0x10 (bit 20) surfaces at out beat 10 = 0x01.
        for (int n = 0; n < NBYTES; n++) begin
            blk[n]  = 8'h00;
            want[n] = 8'h00;
        end
        blk[2]   = 8'h10;
        want[10] = 8'h01;
        stall_arm = 1;
        applyStimulus(blk, want, t0);
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(bus.out_valid && int'(bus.out_idx) == 10 && !bus.out_ready) && budget < 200);
        checkOutput("stall_reached", 32'(budget < 200), 32'h1);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall_idx", 32'(bus.out_idx), 32'd10);
            checkOutput("stall_data", 32'(bus.out_data), 32'h01);
            checkOutput("stall_valid", 32'(bus.out_valid), 32'h1);
            checkOutput("stall_in_ready", 32'(bus.in_ready), 32'h0);
            if (k < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        stall_arm = 0;
        waitDrain();

        // Round trip: forward-permute a random state with the 4*i mod M map.
        in_gap = 30;
        ready_gap = 30;
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < STATE_BITS; i++) orig[i] = 1'($urandom_range(1));
            for (int i = 0; i < STATE_BITS; i++) begin
                p = (i == M) ? M : ((4 * i) % M);
                perm[i] = orig[p];
            end
            for (int n = 0; n < NBYTES; n++) begin
                blk[n]  = perm[8*n +: 8];
                want[n] = orig[8*n +: 8];
            end
            applyStimulus(blk, want, t0);
        end
        waitDrain();

        // Reset mid-LOAD after 17 beats, then an impulse block must be clean.
        in_gap = 0;
        ready_gap = 0;
        for (int n = 0; n < 17; n++) sendBeat(8'hFF, c);
        checkOutput("busy_load", 32'(bus.busy), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkResetOutputs("mid_load");
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int n = 0; n < NBYTES; n++) begin
            blk[n]  = 8'h00;
            want[n] = 8'h00;
        end
        blk[0]  = 8'h02;
        want[0] = 8'h10;
        applyStimulus(blk, want, t0);
        waitDrain();

        // Reset mid-DRAIN with the sink stalled, then the same impulse block.
        ready_gap = 100;
        for (int n = 0; n < NBYTES; n++) sendBeat(8'hFF, c);
        @(posedge clk);
        #1;
        checkOutput("drain_valid", 32'(bus.out_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkResetOutputs("mid_drain");
        @(posedge clk);
        #1;
        rst = 1'b1;
        ready_gap = 0;
        applyStimulus(blk, want, t0);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inv_player.md
# inv_player

Serial inverse bit-permutation layer for the Spongent state. It accepts the permuted state one byte per cycle and scatters each bit to its pre-permutation position P⁻¹(i) in an internal state register. It then streams the recovered state out one byte per cycle. It sits beside the forward permutation layer as its decoder, for round inversion and for checking forward-layer output in-system.

## Interface
Parameters:
- STATE_BITS, 264, Spongent state width b; must be a multiple of 8.
- NBYTES, STATE_BITS/8 (33), number of byte beats per block.
- IDXW, 6, width of byte-index outputs; must satisfy 2^IDXW ≥ NBYTES.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-low.
- in_data  in  8  permuted-state byte; bit k of beat n is state bit 8n+k.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a byte this cycle.
- out_data  out  8  recovered-state byte; bit k of beat n is state bit 8n+k.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data this cycle.
- out_idx  out  IDXW  byte index of the current out_data beat.
- busy  out  1  high from first accepted input byte until last output byte is accepted.

## Operation
- Mapping: let M = STATE_BITS−1.
  - Input bit i with i < M goes to state position (4·i) mod M.
  - Bit M goes to position M.
  - This is the exact inverse of the forward map j → (j·STATE_BITS/4) mod M.
- Modular product: compute 4·i in ≥11 bits, then reduce mod M. Repeated subtraction or a constant table is acceptable.
- FSM, two states:
  - LOAD:
    - in_ready=1, out_valid=0.
    - On in_valid&in_ready, write the 8 bits of in_data into the state register at their mapped positions, and increment cnt.
    - When beat cnt=NBYTES−1 is accepted, clear cnt to 0 and go to DRAIN.
  - DRAIN:
    - in_ready=0, out_valid=1.
    - out_data = state byte [cnt], out_idx = cnt.
    - On out_valid&out_ready, increment cnt.
    - When beat NBYTES−1 is accepted, clear cnt, clear the state register, and go to LOAD.
- Each position is written exactly once per block because the map is a bijection. Clearing the register between blocks is still required for determinism.
- busy:
  - Set on the first accepted input beat.
  - Stays set while in DRAIN.
  - Clears in the cycle the last output beat is accepted.
- in_valid while in DRAIN is ignored, because in_ready=0. Upstream must hold its data.
- out_ready while in LOAD has no effect.

## Timing
Reset values (asynchronous, immediately on rst=0):
- State LOAD, cnt=0, state register 0.
- in_ready=1, out_valid=0, out_data=0, out_idx=0, busy=0.

Latency and throughput:
- The first output beat is valid in the cycle after the last input beat is accepted; latency is 1 cycle.
- out_data, out_valid and out_idx are registered or derived only from registered state. No combinational path exists from in_* to out_*.
- With continuous valid/ready, a block takes NBYTES input cycles plus NBYTES output cycles: 66 cycles at default.

Backpressure:
- out_ready=0 holds out_data, out_idx and out_valid stable.
- in_valid gaps stall cnt without losing data.

Boundary conditions:
- cnt wrap: cnt never exceeds NBYTES−1, and it returns to 0 at each phase change.
- Reset asserted mid-LOAD or mid-DRAIN aborts the block. Partial data is discarded, and the next accepted byte is treated as beat 0.
- Reset release is synchronised by the integrator; the block assumes the release is clean relative to clk.

## Test plan
- Impulse, low bit:
  - Stimulus: beat 0 = 0x02 (bit 1), all other beats 0x00.
  - Required: out beat 0 = 0x10 (position 4), all others 0x00.
- Wrap impulse:
  - Stimulus: beat 8 = 0x04 (bit 66), rest zero.
  - Required: out beat 0 = 0x02, since 264 mod 263 = 1.
  - Also: beat 32 = 0x40 (bit 262) gives out beat 32 = 0x08 (position 259).
- Fixed points:
  - Stimulus: beat 32 = 0x80 (bit 263), then separately beat 0 = 0x01.
  - Required: output unchanged. An all-0xFF block returns all-0xFF with out_idx stepping 0..32.
- Round-trip:
  - Stimulus: random 264-bit state, forward-permuted by the reference model and fed in.
  - Required: the output equals the original state.
  - Repeat 1000 blocks back-to-back with random in_valid/out_ready gaps. Check every value and the 33+33-cycle minimum.
- Backpressure: hold out_ready=0 for 5 cycles at beat 10. Required: out_data, out_idx=10 and out_valid remain stable, and in_ready stays 0.
- Reset mid-operation:
  - Stimulus: assert rst after 17 input beats, release, then feed a full impulse block (beat 0 = 0x02).
  - Required: outputs immediately at reset values, and the next block yields out beat 0 = 0x10 with no residue.
